// File: rtl/perceptron_train_scheduler.sv
// Arbitrates the single-port perceptron weight table between lookups and queued training updates.
// Grants appear on tbl_* one edge later; upd_ready drops when the FIFO is full; define PERCEPTRON_HAZARD_STALL_EN to stall index-hazard lookups.
module perceptron_train_scheduler #(
  parameter int IDX_W      = 6,
  parameter int HIST_W     = 8,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 7
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       lookup_valid,
  input  logic [IDX_W-1:0]           lookup_index,
  output logic                       lookup_ready,
  input  logic                       upd_valid,
  input  logic [IDX_W-1:0]           upd_index,
  input  logic [HIST_W-1:0]          upd_hist,
  input  logic                       upd_dir,
  output logic                       upd_ready,
  output logic                       tbl_en,
  output logic                       tbl_we,
  output logic [IDX_W-1:0]           tbl_addr,
  output logic [HIST_W-1:0]          tbl_hist,
  output logic                       tbl_dir,
  output logic [$clog2(DEPTH+1)-1:0] pend_count,
  output logic                       drain
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX+1) : 1;

  typedef enum logic [1:0] {IDLE, SHARE, DRAIN} state_t;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [HIST_W-1:0] hist;
    logic              dir;
  } upd_t;

  state_t           state, state_nxt;
  upd_t             mem [DEPTH];
  upd_t             head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [STV_W-1:0] starve;
  logic [CNT_W-1:0] cnt_next;
  logic             push, pop, lookup_grant, fifo_empty, starve_force, hazard;

  assign head         = mem[rd_ptr];
  assign fifo_empty   = (pend_count == '0);
  assign starve_force = (starve == STV_W'(STARVE_MAX));
  assign upd_ready    = (pend_count < CNT_W'(DEPTH));
  assign push         = upd_valid && upd_ready;

`ifdef PERCEPTRON_HAZARD_STALL_EN
  // Only occupied slots (head onward, pend_count deep) take part in the compare.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < pend_count) && (mem[rd_ptr + PTR_W'(k)].idx == lookup_index))
        hazard = 1'b1;
    end
  end
`else
  assign hazard = 1'b0;
`endif

  always_comb begin
    case (state)
      IDLE:    lookup_ready = 1'b1;
      SHARE:   lookup_ready = !starve_force && !hazard;
      default: lookup_ready = 1'b0;
    endcase
  end

  // Any cycle the table is not read by a lookup goes to the FIFO head.
  assign lookup_grant = lookup_valid && lookup_ready;
  assign pop          = !fifo_empty && !lookup_grant;
  assign cnt_next     = pend_count + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (push) state_nxt = SHARE;
      SHARE, DRAIN: begin
        if (cnt_next == '0)
          state_nxt = IDLE;
        else if (cnt_next == CNT_W'(DEPTH))
          state_nxt = DRAIN;
        else if ((state == DRAIN) && (cnt_next > CNT_W'(DEPTH/2)))
          state_nxt = DRAIN;
        else
          state_nxt = SHARE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{idx: upd_index, hist: upd_hist, dir: upd_dir};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      drain      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pend_count <= '0;
      starve     <= '0;
      tbl_en     <= 1'b0;
      tbl_we     <= 1'b0;
      tbl_addr   <= '0;
      tbl_hist   <= '0;
      tbl_dir    <= 1'b0;
    end else begin
      state      <= state_nxt;
      drain      <= (state_nxt == DRAIN);
      pend_count <= cnt_next;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      if (pop || state == IDLE)
        starve <= '0;
      else if (lookup_grant && !starve_force)
        starve <= starve + STV_W'(1);

      tbl_en <= lookup_grant || pop;
      if (pop) begin
        tbl_we   <= 1'b1;
        tbl_addr <= head.idx;
        tbl_hist <= head.hist;
        tbl_dir  <= head.dir;
      end else if (lookup_grant) begin
        tbl_we   <= 1'b0;
        tbl_addr <= lookup_index;
        tbl_hist <= '0;
        tbl_dir  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_perceptron_train_scheduler.sv
// Bench for perceptron_train_scheduler: vector table plus hand sequences, table traffic checked through a scoreboard.
module tb_perceptron_train_scheduler;
  localparam int IDX_W = 6, HIST_W = 8, DEPTH = 4, STARVE_MAX = 7;

  logic              clk, reset_n;
  logic              lookup_valid, lookup_ready, upd_valid, upd_dir, upd_ready;
  logic [IDX_W-1:0]  lookup_index, upd_index, tbl_addr;
  logic [HIST_W-1:0] upd_hist, tbl_hist;
  logic              tbl_en, tbl_we, tbl_dir, drain;
  logic [2:0]        pend_count;

  typedef struct packed {
    logic       we;
    logic [5:0] addr;
    logic [7:0] hist;
    logic       dir;
  } tx_t;

  typedef struct {
    logic lv; logic [5:0] li;
    logic uv; logic [5:0] ui; logic [7:0] uh; logic ud;
    logic exp_lr; logic exp_ur; logic [2:0] exp_cnt;
    logic exp_tx; tx_t tx;
  } vec_t;

  tx_t  sb[$];
  vec_t vecs[9];
  logic [7:0] hv[4];
  int n_cmp = 0, n_err = 0;

  perceptron_train_scheduler #(.IDX_W(IDX_W), .HIST_W(HIST_W), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .lookup_valid(lookup_valid), .lookup_index(lookup_index), .lookup_ready(lookup_ready),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_hist(upd_hist), .upd_dir(upd_dir),
    .upd_ready(upd_ready),
    .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_hist(tbl_hist), .tbl_dir(tbl_dir),
    .pend_count(pend_count), .drain(drain)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic tx_t rd(input logic [5:0] a);
    return '{we: 1'b0, addr: a, hist: 8'h00, dir: 1'b0};
  endfunction

  function automatic tx_t wr(input logic [5:0] a, input logic [7:0] h, input logic d);
    return '{we: 1'b1, addr: a, hist: h, dir: d};
  endfunction

  // Inputs change 1 time unit after the rising edge; checks run one unit later.
  task automatic step(input logic lv, input logic [5:0] li, input logic uv,
                      input logic [5:0] ui, input logic [7:0] uh, input logic ud);
    @(posedge clk);
    #1;
    lookup_valid = lv; lookup_index = li;
    upd_valid = uv; upd_index = ui; upd_hist = uh; upd_dir = ud;
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 6'd0, 1'b0, 6'd0, 8'h00, 1'b0);
  endtask

  // Every table access must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    tx_t e;
    if (reset_n && tbl_en) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL tbl_unexpected: got we=%0b addr=%0d, expected no access", tbl_we, tbl_addr);
      end else begin
        e = sb.pop_front();
        chk("tbl_tx", 32'({tbl_we, tbl_addr, tbl_hist, tbl_dir}), 32'(e));
      end
    end
  end

  initial begin
    reset_n = 1'b1;
    lookup_valid = 0; lookup_index = 0; upd_valid = 0; upd_index = 0; upd_hist = 0; upd_dir = 0;
    #1 reset_n = 1'b0;
    #11;
    chk("rst_lookup_ready", 32'(lookup_ready), 1);
    chk("rst_upd_ready", 32'(upd_ready), 1);
    chk("rst_pend_count", 32'(pend_count), 0);
    chk("rst_drain", 32'(drain), 0);
    chk("rst_tbl", 32'({tbl_en, tbl_we, tbl_addr, tbl_hist, tbl_dir}), 0);

    @(posedge clk); #1 reset_n = 1'b1;

    // First lookup after reset.
    step(1'b1, 6'd5, 1'b0, 6'd0, 8'h00, 1'b0);
    chk("t1_lookup_ready", 32'(lookup_ready), 1);
    sb.push_back(rd(6'd5));
    idle_step();
    chk("t1_tbl_en", 32'(tbl_en), 1);
    chk("t1_tbl_we", 32'(tbl_we), 0);

    // Single update: written two edges after the push, then back to empty.
    step(1'b0, 6'd0, 1'b1, 6'd9, 8'hA5, 1'b1);
    sb.push_back(wr(6'd9, 8'hA5, 1'b1));
    idle_step();
    chk("t2_pend_one", 32'(pend_count), 1);
    chk("t2_no_early_write", 32'(tbl_en), 0);
    idle_step();
    chk("t2_tbl_we", 32'(tbl_we), 1);
    chk("t2_pend_zero", 32'(pend_count), 0);
    chk("t2_drain", 32'(drain), 0);

    vecs[0] = '{1, 6'd3,  0, 6'd0,  8'h00, 0, 1, 1, 3'd0, 1, rd(6'd3)};
    vecs[1] = '{0, 6'd0,  1, 6'd9,  8'hA5, 1, 1, 1, 3'd0, 0, tx_t'(0)};
    vecs[2] = '{0, 6'd0,  0, 6'd0,  8'h00, 0, 1, 1, 3'd1, 1, wr(6'd9, 8'hA5, 1)};
    vecs[3] = '{1, 6'd7,  1, 6'd2,  8'h3C, 0, 1, 1, 3'd0, 1, rd(6'd7)};
    vecs[4] = '{1, 6'd8,  1, 6'd4,  8'hF0, 1, 1, 1, 3'd1, 1, rd(6'd8)};
    vecs[5] = '{0, 6'd0,  0, 6'd0,  8'h00, 0, 1, 1, 3'd2, 1, wr(6'd2, 8'h3C, 0)};
    vecs[6] = '{0, 6'd0,  1, 6'd11, 8'h81, 0, 1, 1, 3'd1, 1, wr(6'd4, 8'hF0, 1)};
    vecs[7] = '{0, 6'd0,  0, 6'd0,  8'h00, 0, 1, 1, 3'd1, 1, wr(6'd11, 8'h81, 0)};
    vecs[8] = '{1, 6'd63, 0, 6'd0,  8'h00, 0, 1, 1, 3'd0, 1, rd(6'd63)};
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].lv, vecs[i].li, vecs[i].uv, vecs[i].ui, vecs[i].uh, vecs[i].ud);
      chk($sformatf("vec%0d_lookup_ready", i), 32'(lookup_ready), 32'(vecs[i].exp_lr));
      chk($sformatf("vec%0d_upd_ready", i), 32'(upd_ready), 32'(vecs[i].exp_ur));
      chk($sformatf("vec%0d_pend_count", i), 32'(pend_count), 32'(vecs[i].exp_cnt));
      if (vecs[i].exp_tx) sb.push_back(vecs[i].tx);
    end
    idle_step();
    chk("vec_end_pend", 32'(pend_count), 0);

    // Starvation: seven lookups win, then the update is forced for one cycle.
    step(1'b1, 6'd30, 1'b1, 6'd20, 8'h55, 1'b1);
    chk("st_first_grant", 32'(lookup_ready), 1);
    sb.push_back(rd(6'd30));
    for (int i = 1; i <= 7; i++) begin
      step(1'b1, 6'(30 + i), 1'b0, 6'd0, 8'h00, 1'b0);
      chk($sformatf("st_grant%0d", i), 32'(lookup_ready), 1);
      sb.push_back(rd(6'(30 + i)));
    end
    step(1'b1, 6'd38, 1'b0, 6'd0, 8'h00, 1'b0);
    chk("st_forced_stall", 32'(lookup_ready), 0);
    sb.push_back(wr(6'd20, 8'h55, 1'b1));
    step(1'b1, 6'd39, 1'b0, 6'd0, 8'h00, 1'b0);
    chk("st_after_ready", 32'(lookup_ready), 1);
    chk("st_after_pend", 32'(pend_count), 0);
    sb.push_back(rd(6'd39));
    idle_step();

    // Fill the FIFO under continuous lookups: two-cycle drain back to half full.
    for (int k = 0; k < 4; k++) begin
      hv[k] = 8'(k * 17 + 1);
      step(1'b1, 6'(k), 1'b1, 6'(40 + k), hv[k], k[0]);
      chk($sformatf("dr_fill%0d_ready", k), 32'(lookup_ready), 1);
      chk($sformatf("dr_fill%0d_pend", k), 32'(pend_count), 32'(k));
      sb.push_back(rd(6'(k)));
    end
    step(1'b1, 6'd10, 1'b1, 6'd50, 8'hEE, 1'b1);
    chk("dr_full_pend", 32'(pend_count), 4);
    chk("dr_full_upd_ready", 32'(upd_ready), 0);
    chk("dr_drain1", 32'(drain), 1);
    chk("dr_stall1", 32'(lookup_ready), 0);
    sb.push_back(wr(6'd40, hv[0], 1'b0));
    step(1'b1, 6'd11, 1'b0, 6'd0, 8'h00, 1'b0);
    chk("dr_pend3", 32'(pend_count), 3);
    chk("dr_drain2", 32'(drain), 1);
    chk("dr_stall2", 32'(lookup_ready), 0);
    sb.push_back(wr(6'd41, hv[1], 1'b1));
    step(1'b1, 6'd12, 1'b0, 6'd0, 8'h00, 1'b0);
    chk("dr_share_pend", 32'(pend_count), 2);
    chk("dr_share_drain", 32'(drain), 0);
    chk("dr_share_ready", 32'(lookup_ready), 1);
    sb.push_back(rd(6'd12));
    idle_step();
    sb.push_back(wr(6'd42, hv[2], 1'b0));
    idle_step();
    sb.push_back(wr(6'd43, hv[3], 1'b1));
    idle_step();
    chk("dr_empty_pend", 32'(pend_count), 0);

    // Reset asserted mid-drain discards queued work.
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 6'(k), 1'b1, 6'(20 + k), 8'h11, 1'b0);
      sb.push_back(rd(6'(k)));
    end
    step(1'b1, 6'd10, 1'b0, 6'd0, 8'h00, 1'b0);
    chk("rd_drain_in", 32'(drain), 1);
    step(1'b1, 6'd11, 1'b0, 6'd0, 8'h00, 1'b0);
    chk("rd_pend3", 32'(pend_count), 3);
    #1;
    sb.delete();
    reset_n = 1'b0;
    #1;
    chk("rd_pend_cleared", 32'(pend_count), 0);
    chk("rd_drain_cleared", 32'(drain), 0);
    chk("rd_tbl_en_cleared", 32'(tbl_en), 0);
    chk("rd_lookup_ready", 32'(lookup_ready), 1);
    chk("rd_upd_ready", 32'(upd_ready), 1);
    @(posedge clk); @(posedge clk); #1;
    lookup_valid = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idle_step();
      chk($sformatf("rd_quiet%0d", i), 32'({tbl_en, tbl_we, pend_count}), 0);
    end

    // Lookup to an index that has a queued update.
    step(1'b0, 6'd0, 1'b1, 6'd12, 8'h3C, 1'b0);
    step(1'b1, 6'd12, 1'b0, 6'd0, 8'h00, 1'b0);
`ifdef PERCEPTRON_HAZARD_STALL_EN
    chk("hz_stall", 32'(lookup_ready), 0);
    sb.push_back(wr(6'd12, 8'h3C, 1'b0));
    step(1'b1, 6'd12, 1'b0, 6'd0, 8'h00, 1'b0);
    chk("hz_grant_after", 32'(lookup_ready), 1);
    sb.push_back(rd(6'd12));
`else
    chk("hz_grant_first", 32'(lookup_ready), 1);
    sb.push_back(rd(6'd12));
    idle_step();
    sb.push_back(wr(6'd12, 8'h3C, 1'b0));
`endif
    idle_step();
    idle_step();
    chk("hz_pend", 32'(pend_count), 0);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
